// File: rtl/count_stream_checker.sv
// count_stream_checker
//
// Receive-side checker for a 4-bit free-running count stream from an
// external source. The value and its toggle strobe are synchronised into
// clk. Each strobe edge delivers one value. The block checks that each value
// is the previous value plus one (mod 16), tracks lock, flags a stalled
// stream and keeps a saturating count of sequence breaks.
//
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   ena       in   enable; when low the FSM, counters and idle timer freeze
//                  and receive events are dropped (synchronisers keep running)
//   din       in   [3:0] incoming count value
//   din_tgl   in   toggle strobe; every level change marks one new value
//   clr_err   in   synchronous clear of err_cnt
//   rx_pulse  out  one-cycle pulse per received value
//   last_val  out  [3:0] most recently received value
//   locked    out  high in LOCKED
//   stalled   out  high in STALL
//   err_cnt   out  [7:0] saturating sequence-break count
//
// state  | meaning
// -------+--------------------------------------------------------------
// HUNT   | no reference yet; the next value seeds the expected value
// ACQ    | counting consecutive in-sequence values towards LOCK_COUNT
// LOCKED | in sequence; mismatches are counted, the idle timer runs
// STALL  | no value for TIMEOUT_CYCLES while locked; the next value re-acquires

module count_stream_checker #(
    parameter int SYNC_STAGES    = 2,
    parameter int LOCK_COUNT     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] din,
    input  logic       din_tgl,
    input  logic       clr_err,
    output logic       rx_pulse,
    output logic [3:0] last_val,
    output logic       locked,
    output logic       stalled,
    output logic [7:0] err_cnt
);

    localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TIMEOUT_TC = TW'(TIMEOUT_CYCLES);
    localparam logic [3:0]      LOCK_TC    = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2,
        STALL  = 2'd3
    } state_t;

    state_t                           state, state_nx;
    logic [SYNC_STAGES-1:0][3:0]      din_sync;
    logic [SYNC_STAGES-1:0]           tgl_sync;
    logic                             tgl_prev;
    logic [3:0]                       expected, expected_nx;
    logic [3:0]                       good, good_nx;
    logic [7:0]                       err_nx;
    logic [TW-1:0]                    idle_cnt, idle_nx;
    logic                             err_inc;
    logic                             rx_evt;
    logic [3:0]                       rx_val;

    // din and din_tgl share the same depth so the value is settled whenever
    // the toggle edge emerges from the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_sync <= '0;
            tgl_sync <= '0;
            tgl_prev <= 1'b0;
        end else begin
            din_sync <= {din_sync[SYNC_STAGES-2:0], din};
            tgl_sync <= {tgl_sync[SYNC_STAGES-2:0], din_tgl};
            // Tracks even while disabled, so a toggle seen with ena low is
            // consumed rather than replayed on re-enable.
            tgl_prev <= tgl_sync[SYNC_STAGES-1];
        end
    end

    assign rx_val = din_sync[SYNC_STAGES-1];
    assign rx_evt = ena && (tgl_sync[SYNC_STAGES-1] != tgl_prev);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            expected <= '0;
            good     <= '0;
            err_cnt  <= '0;
            idle_cnt <= '0;
            rx_pulse <= 1'b0;
            last_val <= '0;
        end else begin
            state    <= state_nx;
            expected <= expected_nx;
            good     <= good_nx;
            err_cnt  <= err_nx;
            idle_cnt <= idle_nx;
            rx_pulse <= rx_evt;
            if (rx_evt) begin
                last_val <= rx_val;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        expected_nx = expected;
        good_nx     = good;
        idle_nx     = idle_cnt;
        err_inc     = 1'b0;

        if (rx_evt) begin
            idle_nx     = '0;
            expected_nx = rx_val + 4'd1;
            case (state)
                HUNT, STALL: begin
                    good_nx  = 4'd1;
                    state_nx = ACQ;
                end
                ACQ: begin
                    if (rx_val == expected) begin
                        good_nx = good + 4'd1;
                        if (good_nx == LOCK_TC) begin
                            state_nx = LOCKED;
                        end
                    end else begin
                        good_nx = 4'd1;
                    end
                end
                LOCKED: begin
                    if (rx_val != expected) begin
                        err_inc  = 1'b1;
                        good_nx  = 4'd1;
                        state_nx = ACQ;
                    end
                end
                default: state_nx = HUNT;
            endcase
        end else if (ena && state == LOCKED) begin
            idle_nx = idle_cnt + 1'b1;
            if (idle_nx == TIMEOUT_TC) begin
                state_nx = STALL;
            end
        end
    end

    // Clear has priority over a coincident increment; increments stop at 255.
    always_comb begin
        err_nx = err_cnt;
        if (clr_err) begin
            err_nx = '0;
        end else if (err_inc && err_cnt != 8'hFF) begin
            err_nx = err_cnt + 8'd1;
        end
    end

    assign locked  = (state == LOCKED);
    assign stalled = (state == STALL);

endmodule

// File: tb/tb_count_stream_checker.sv
// Directed testbench for count_stream_checker (default parameters).
module tb_count_stream_checker;

    localparam int TIMEOUT = 1024;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [3:0] din;
    logic       din_tgl;
    logic       clr_err;
    logic       rx_pulse;
    logic [3:0] last_val;
    logic       locked;
    logic       stalled;
    logic [7:0] err_cnt;

    int errors = 0;
    int checks = 0;

    logic [3:0] cur;
    logic [3:0] m;

    count_stream_checker #(
        .SYNC_STAGES   (2),
        .LOCK_COUNT    (4),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .din     (din),
        .din_tgl (din_tgl),
        .clr_err (clr_err),
        .rx_pulse(rx_pulse),
        .last_val(last_val),
        .locked  (locked),
        .stalled (stalled),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One value: din set, toggle one cycle later, pulse expected after the
    // third edge that follows the toggle, gone after the fourth.
    task automatic send(input logic [3:0] v, input bit chk, input logic exp_lock,
                        input logic [7:0] exp_err, input string tag);
        din = v;
        @(posedge clk); #1;
        din_tgl = ~din_tgl;
        @(posedge clk);
        @(posedge clk); #1;
        if (chk) check($sformatf("%s early_pulse", tag), {7'd0, rx_pulse}, 8'd0);
        @(posedge clk); #1;
        if (chk) begin
            check($sformatf("%s rx_pulse", tag), {7'd0, rx_pulse}, 8'd1);
            check($sformatf("%s last_val", tag), {4'd0, last_val}, {4'd0, v});
            check($sformatf("%s locked", tag), {7'd0, locked}, {7'd0, exp_lock});
            check($sformatf("%s stalled", tag), {7'd0, stalled}, 8'd0);
            check($sformatf("%s err_cnt", tag), err_cnt, exp_err);
        end
        @(posedge clk); #1;
        if (chk) check($sformatf("%s pulse_end", tag), {7'd0, rx_pulse}, 8'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        ena     = 1'b1;
        din     = 4'd0;
        din_tgl = 1'b0;
        clr_err = 1'b0;
        #12;
        check("rst rx_pulse", {7'd0, rx_pulse}, 8'd0);
        check("rst last_val", {4'd0, last_val}, 8'd0);
        check("rst locked",   {7'd0, locked},   8'd0);
        check("rst stalled",  {7'd0, stalled},  8'd0);
        check("rst err_cnt",  err_cnt,          8'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Acquire: lock on the fourth in-sequence value.
        send(4'd0, 1, 1'b0, 8'd0, "acq0");
        send(4'd1, 1, 1'b0, 8'd0, "acq1");
        send(4'd2, 1, 1'b0, 8'd0, "acq2");
        send(4'd3, 1, 1'b1, 8'd0, "acq3");

        // Run through 13,14,15,0,1 to cover the wrap.
        for (int v = 4; v < 18; v++) begin
            cur = 4'(v);
            send(cur, 1, 1'b1, 8'd0, $sformatf("wrap%0d", v));
        end

        // Continue to 8, then 5 where 9 is expected.
        for (int v = 2; v <= 8; v++) send(4'(v), 1, 1'b1, 8'd0, "seq");
        send(4'd5, 1, 1'b0, 8'd1, "mis5");
        send(4'd6, 1, 1'b0, 8'd1, "re6");
        send(4'd7, 1, 1'b0, 8'd1, "re7");
        send(4'd8, 1, 1'b1, 8'd1, "re8");

        // Idle: pulse was three cycles into send, we are one cycle past it.
        for (int i = 0; i < TIMEOUT - 2; i++) @(posedge clk);
        #1;
        check("stall_pre stalled", {7'd0, stalled}, 8'd0);
        check("stall_pre locked",  {7'd0, locked},  8'd1);
        @(posedge clk); #1;
        check("stall stalled", {7'd0, stalled}, 8'd1);
        check("stall locked",  {7'd0, locked},  8'd0);
        send(4'd3, 1, 1'b0, 8'd1, "unstall");
        send(4'd4, 1, 1'b0, 8'd1, "acq4");
        send(4'd5, 1, 1'b0, 8'd1, "acq5");
        send(4'd6, 1, 1'b1, 8'd1, "acq6");
        cur = 4'd6;

        // Drive err_cnt to saturation: one counted break per relock.
        for (int r = 0; r < 254; r++) begin
            m = cur + 4'd8;
            send(m, 0, 1'b0, 8'd0, "sat");
            send(m + 4'd1, 0, 1'b0, 8'd0, "sat");
            send(m + 4'd2, 0, 1'b0, 8'd0, "sat");
            send(m + 4'd3, 0, 1'b0, 8'd0, "sat");
            cur = m + 4'd3;
        end
        check("sat err_cnt", err_cnt, 8'd255);
        check("sat locked",  {7'd0, locked}, 8'd1);
        m = cur + 4'd8;
        send(m, 1, 1'b0, 8'd255, "hold255");
        send(m + 4'd1, 1, 1'b0, 8'd255, "hold_r1");
        send(m + 4'd2, 1, 1'b0, 8'd255, "hold_r2");
        send(m + 4'd3, 1, 1'b1, 8'd255, "hold_r3");
        cur = m + 4'd3;

        // Clear coincident with a mismatch.
        m = cur + 4'd8;
        din = m;
        @(posedge clk); #1;
        din_tgl = ~din_tgl;
        @(posedge clk);
        @(posedge clk); #1;
        clr_err = 1'b1;
        @(posedge clk); #1;
        clr_err = 1'b0;
        check("clr rx_pulse", {7'd0, rx_pulse}, 8'd1);
        check("clr err_cnt",  err_cnt,          8'd0);
        check("clr locked",   {7'd0, locked},   8'd0);
        @(posedge clk); #1;
        send(m + 4'd1, 1, 1'b0, 8'd0, "post_clr1");
        send(m + 4'd2, 1, 1'b0, 8'd0, "post_clr2");
        send(m + 4'd3, 1, 1'b1, 8'd0, "post_clr3");
        cur = m + 4'd3;
        m = cur + 4'd8;
        send(m, 1, 1'b0, 8'd1, "count_again");
        send(m + 4'd1, 1, 1'b0, 8'd1, "en_r1");
        send(m + 4'd2, 1, 1'b0, 8'd1, "en_r2");
        send(m + 4'd3, 1, 1'b1, 8'd1, "en_r3");
        cur = m + 4'd3;

        // Toggle with ena low is discarded; no replay on re-enable.
        ena = 1'b0;
        din = cur + 4'd8;
        @(posedge clk); #1;
        din_tgl = ~din_tgl;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("ena_lo rx_pulse", {7'd0, rx_pulse}, 8'd0);
        end
        ena = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("ena_hi rx_pulse", {7'd0, rx_pulse}, 8'd0);
        end
        check("ena last_val", {4'd0, last_val}, {4'd0, cur});
        check("ena locked",   {7'd0, locked},   8'd1);
        check("ena err_cnt",  err_cnt,          8'd1);
        send(cur + 4'd1, 1, 1'b1, 8'd1, "ena_next");
        cur = cur + 4'd1;

        // Reset mid-stream, in the middle of a value's synchronisation.
        din = cur + 4'd1;
        @(posedge clk); #1;
        din_tgl = ~din_tgl;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mrst rx_pulse", {7'd0, rx_pulse}, 8'd0);
        check("mrst last_val", {4'd0, last_val}, 8'd0);
        check("mrst locked",   {7'd0, locked},   8'd0);
        check("mrst stalled",  {7'd0, stalled},  8'd0);
        check("mrst err_cnt",  err_cnt,          8'd0);
        din_tgl = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst rx_pulse", {7'd0, rx_pulse}, 8'd0);
        check("post_rst locked",   {7'd0, locked},   8'd0);
        send(4'd7,  1, 1'b0, 8'd0, "hunt7");
        send(4'd8,  1, 1'b0, 8'd0, "hunt8");
        send(4'd9,  1, 1'b0, 8'd0, "hunt9");
        send(4'd10, 1, 1'b1, 8'd0, "hunt10");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
